// File: rtl/router_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_pkg
//  Description : Shared constants for the router packet fragmenter and
//                reassembler: widths, fragment header field offsets and
//                the reassembler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkt_pkg;

    // Widths
    localparam int PKT_WIDTH          = 1041;  // 1034 data+addr, 1 ack, 2 seq, 4 dfx
    localparam int AURORA_WIDTH       = 256;
    localparam int ROUTER_WIDTH       = 2;
    localparam int FRAG_PAYLOAD_WIDTH = AURORA_WIDTH - 9;
    localparam int LAST_FRAG          = 4;
    localparam int TAIL_WIDTH         = PKT_WIDTH - LAST_FRAG * FRAG_PAYLOAD_WIDTH;  // 53
    localparam int FNUM_WIDTH         = 3;
    localparam int TTL_WIDTH          = 2;
    localparam int TIMEOUT_CYCLES     = 64;

    // Fragment header field offsets
    localparam int SRC_LSB     = 0;
    localparam int DST_LSB     = 2;
    localparam int FNUM_LSB    = 4;
    localparam int TTL_LSB     = 7;
    localparam int PAYLOAD_LSB = 9;

    // Reassembler state encoding
    localparam int              STATE_WIDTH  = 2;
    localparam logic [1:0]      c_ST_IDLE    = 2'd0;
    localparam logic [1:0]      c_ST_COLLECT = 2'd1;
    localparam logic [1:0]      c_ST_HOLD    = 2'd2;

    localparam logic [FNUM_WIDTH-1:0] c_LAST_FNUM = FNUM_WIDTH'(LAST_FRAG);

endpackage
`default_nettype wire

// File: rtl/reassemble_pkt_hdr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : frag_hdr_decode
//  Description : Combinational split of an Aurora fragment into header
//                fields and payload, plus destination-match and
//                sequence-match flags for the reassembler FSM.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_frag         in   fragment word
//    i_local_router in   this router's ID
//    i_exp_fnum     in   fragment number expected next
//    i_cur_src      in   source router latched for the packet in progress
//    o_src          out  fragment source router
//    o_fnum         out  fragment number
//    o_payload      out  fragment payload
//    o_dst_match    out  fragment addressed to this router
//    o_seq_match    out  fragment is the expected number from the latched source
// ============================================================================
module frag_hdr_decode
    import router_pkt_pkg::*;
(
    input  logic [AURORA_WIDTH-1:0]       i_frag,
    input  logic [ROUTER_WIDTH-1:0]       i_local_router,
    input  logic [FNUM_WIDTH-1:0]         i_exp_fnum,
    input  logic [ROUTER_WIDTH-1:0]       i_cur_src,
    output logic [ROUTER_WIDTH-1:0]       o_src,
    output logic [FNUM_WIDTH-1:0]         o_fnum,
    output logic [FRAG_PAYLOAD_WIDTH-1:0] o_payload,
    output logic                          o_dst_match,
    output logic                          o_seq_match
);

    logic [ROUTER_WIDTH-1:0] w_dst;
    logic [TTL_WIDTH-1:0]    w_unused_ttl;  // TTL is carried but not checked here

    assign o_src        = i_frag[SRC_LSB  +: ROUTER_WIDTH];
    assign w_dst        = i_frag[DST_LSB  +: ROUTER_WIDTH];
    assign o_fnum       = i_frag[FNUM_LSB +: FNUM_WIDTH];
    assign w_unused_ttl = i_frag[TTL_LSB  +: TTL_WIDTH];
    assign o_payload    = i_frag[PAYLOAD_LSB +: FRAG_PAYLOAD_WIDTH];

    assign o_dst_match  = (w_dst == i_local_router);
    assign o_seq_match  = (o_fnum == i_exp_fnum) && (o_src == i_cur_src);

endmodule
`default_nettype wire

// File: rtl/reassemble_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : reassemble_pkt
//  Description : Rebuilds a 1041-bit encapsulated packet from five 256-bit
//                Aurora fragments (frag_num 0..4) and hands it downstream
//                with a valid/ready handshake. Misrouted fragments are
//                dropped; sequence or source errors abort the partial packet.
//                Optional inter-fragment timeout: define REASM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   clock
//    rst            in   synchronous active-high reset
//    local_router   in   this router's ID
//    frag_recv      in   fragment {payload, ttl, frag_num, dst, src}
//    frag_valid     in   fragment present
//    frag_ready     out  fragment consumed when frag_valid && frag_ready
//    pkt_data       out  reassembled packet
//    pkt_src_router out  source router of pkt_data
//    pkt_valid      out  packet available, held until accepted
//    pkt_ready      in   downstream accepts packet
//    frag_drop      out  one-cycle pulse: fragment discarded
//    frag_err       out  one-cycle pulse: partial packet aborted
// ============================================================================
module reassemble_pkt
    import router_pkt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROUTER_WIDTH-1:0] local_router,
    input  logic [AURORA_WIDTH-1:0] frag_recv,
    input  logic                    frag_valid,
    output logic                    frag_ready,
    output logic [PKT_WIDTH-1:0]    pkt_data,
    output logic [ROUTER_WIDTH-1:0] pkt_src_router,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic                    frag_drop,
    output logic                    frag_err
);

    logic [STATE_WIDTH-1:0]        r_state, w_state_nxt;
    logic [FNUM_WIDTH-1:0]         r_exp_fnum, w_exp_nxt;
    logic [ROUTER_WIDTH-1:0]       r_src, w_src_nxt;
    logic                          r_pkt_valid, w_valid_nxt;
    logic                          r_drop, w_drop_nxt;
    logic                          r_err, w_err_nxt;
    logic                          w_wr_en;
    logic [PKT_WIDTH-1:0]          r_pkt_data;

    logic [ROUTER_WIDTH-1:0]       w_src;
    logic [FNUM_WIDTH-1:0]         w_fnum;
    logic [FRAG_PAYLOAD_WIDTH-1:0] w_payload;
    logic                          w_dst_match;
    logic                          w_seq_match;
    logic                          w_accept;
    logic                          w_timeout;

    frag_hdr_decode u_hdr_decode (
        .i_frag         (frag_recv),
        .i_local_router (local_router),
        .i_exp_fnum     (r_exp_fnum),
        .i_cur_src      (r_src),
        .o_src          (w_src),
        .o_fnum         (w_fnum),
        .o_payload      (w_payload),
        .o_dst_match    (w_dst_match),
        .o_seq_match    (w_seq_match)
    );

    assign frag_ready = (r_state == c_ST_IDLE) || (r_state == c_ST_COLLECT);
    assign w_accept   = frag_valid && frag_ready;

`ifdef REASM_TIMEOUT_EN
    localparam int c_TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMR_WIDTH-1:0] r_timer;

    // Counts idle cycles in COLLECT since the last accepted fragment.
    always_ff @(posedge clk) begin
        if (rst)
            r_timer <= '0;
        else if (w_accept || (r_state != c_ST_COLLECT))
            r_timer <= '0;
        else
            r_timer <= r_timer + 1'b1;
    end

    assign w_timeout = (r_state == c_ST_COLLECT) && !w_accept &&
                       (r_timer == c_TMR_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_exp_fnum  <= '0;
            r_src       <= '0;
            r_pkt_valid <= 1'b0;
            r_drop      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_fnum  <= w_exp_nxt;
            r_src       <= w_src_nxt;
            r_pkt_valid <= w_valid_nxt;
            r_drop      <= w_drop_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state and control decisions
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp_fnum;
        w_src_nxt   = r_src;
        w_valid_nxt = r_pkt_valid;
        w_drop_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr_en     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (!w_dst_match || (w_fnum != '0)) begin
                        w_drop_nxt = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_src_nxt   = w_src;
                        w_exp_nxt   = FNUM_WIDTH'(1);
                        w_state_nxt = c_ST_COLLECT;
                    end
                end
            end

            c_ST_COLLECT: begin
                if (w_accept) begin
                    if (!w_dst_match) begin
                        w_drop_nxt = 1'b1;
                    end else if (w_seq_match) begin
                        w_wr_en = 1'b1;
                        if (w_fnum == c_LAST_FNUM) begin
                            w_valid_nxt = 1'b1;
                            w_state_nxt = c_ST_HOLD;
                        end else begin
                            w_exp_nxt = r_exp_fnum + 1'b1;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                        // A fresh fragment 0 starts the next packet immediately
                        if (w_fnum == '0) begin
                            w_wr_en   = 1'b1;
                            w_src_nxt = w_src;
                            w_exp_nxt = FNUM_WIDTH'(1);
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end

            c_ST_HOLD: begin
                if (r_pkt_valid && pkt_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Packet datapath: each accepted fragment overwrites its own slice;
    // the last fragment only contributes the short tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_data <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < LAST_FRAG; i++) begin
                if (w_fnum == FNUM_WIDTH'(i))
                    r_pkt_data[i*FRAG_PAYLOAD_WIDTH +: FRAG_PAYLOAD_WIDTH] <= w_payload;
            end
            if (w_fnum == c_LAST_FNUM)
                r_pkt_data[PKT_WIDTH-1 -: TAIL_WIDTH] <= w_payload[TAIL_WIDTH-1:0];
        end
    end

    assign pkt_data       = r_pkt_data;
    assign pkt_src_router = r_src;
    assign pkt_valid      = r_pkt_valid;
    assign frag_drop      = r_drop;
    assign frag_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reassemble_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reassemble_pkt
//  Description : Directed self-checking bench for reassemble_pkt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reassemble_pkt;

    logic          clk;
    logic          rst;
    logic [1:0]    local_router;
    logic [255:0]  frag_recv;
    logic          frag_valid;
    logic          frag_ready;
    logic [1040:0] pkt_data;
    logic [1:0]    pkt_src_router;
    logic          pkt_valid;
    logic          pkt_ready;
    logic          frag_drop;
    logic          frag_err;

    int n_vec     = 0;
    int n_miscmp  = 0;

    reassemble_pkt dut (
        .clk            (clk),
        .rst            (rst),
        .local_router   (local_router),
        .frag_recv      (frag_recv),
        .frag_valid     (frag_valid),
        .frag_ready     (frag_ready),
        .pkt_data       (pkt_data),
        .pkt_src_router (pkt_src_router),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .frag_drop      (frag_drop),
        .frag_err       (frag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Distinct, full-width payload for packet b, fragment i
    function automatic logic [246:0] pay(input int b, input int i);
        return {b[31:0], 183'h0, i[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [1:0] d,
                         input logic [2:0] n, input logic [246:0] p);
        frag_recv  = {p, 2'b11, n, d, s};
        frag_valid = 1'b1;
    endtask

    // One fragment presented for exactly one cycle
    task automatic send(input logic [1:0] s, input logic [1:0] d,
                        input logic [2:0] n, input logic [246:0] p);
        drive(s, d, n, p);
        step();
        frag_valid = 1'b0;
    endtask

    task automatic chk_pkt(input string tag, input int b, input logic [1:0] s);
        logic [246:0] e;
        logic [1040:0] d;
        d = pkt_data;
        for (int i = 0; i < 4; i++) begin
            e = pay(b, i);
            chk($sformatf("%s_slice%0d", tag, i), d[i*247 +: 247], e);
        end
        e = pay(b, 4);
        chk($sformatf("%s_tail", tag), d[1040:988], e[52:0]);
        chk($sformatf("%s_src", tag), pkt_src_router, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1040:0] d;
        logic [246:0]  e;
        logic          any_err;

        rst          = 1'b1;
        local_router = 2'b01;
        frag_recv    = '0;
        frag_valid   = 1'b0;
        pkt_ready    = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", pkt_valid, 1'b0);
        chk("rst_ready", frag_ready, 1'b1);
        chk("rst_drop", frag_drop, 1'b0);
        chk("rst_err", frag_err, 1'b0);
        chk("rst_src", pkt_src_router, 2'd0);
        d = pkt_data;
        chk("rst_data_lo", d[255:0], 256'h0);
        chk("rst_data_hi", d[1040:988], 53'h0);
        rst = 1'b0;
        step();

        // In-order packet, downstream ready
        pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(2'd2, 2'd1, 3'(i), pay(1, i));
        chk("inord_novalid", pkt_valid, 1'b0);
        send(2'd2, 2'd1, 3'd4, pay(1, 4));
        chk("inord_valid", pkt_valid, 1'b1);
        chk("inord_hold_ready", frag_ready, 1'b0);
        chk_pkt("inord", 1, 2'd2);
        step();
        chk("inord_hs_valid", pkt_valid, 1'b0);
        chk("inord_hs_ready", frag_ready, 1'b1);

        // Backpressure with next packet's fragment 0 waiting
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(2'd2, 2'd1, 3'(i), pay(2, i));
        chk("bp_valid", pkt_valid, 1'b1);
        drive(2'd2, 2'd1, 3'd0, pay(3, 0));
        e = pay(2, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_ready", frag_ready, 1'b0);
            chk("bp_hold_valid", pkt_valid, 1'b1);
            d = pkt_data;
            chk("bp_stable", d[246:0], e);
        end
        chk_pkt("bp", 2, 2'd2);
        pkt_ready = 1'b1;
        step();  // handshake cycle: fragment not taken
        chk("bp_hs_valid", pkt_valid, 1'b0);
        chk("bp_hs_ready", frag_ready, 1'b1);
        step();  // fragment 0 accepted now
        chk("bp_f0_err", frag_err, 1'b0);
        chk("bp_f0_drop", frag_drop, 1'b0);
        for (int i = 1; i < 5; i++) send(2'd2, 2'd1, 3'(i), pay(3, i));
        chk("bp2_valid", pkt_valid, 1'b1);
        chk_pkt("bp2", 3, 2'd2);
        step();

        // Misrouted fragment mid-packet
        send(2'd2, 2'd1, 3'd0, pay(4, 0));
        send(2'd2, 2'd1, 3'd1, pay(4, 1));
        send(2'd2, 2'd3, 3'd2, pay(9, 9));
        chk("mis_drop", frag_drop, 1'b1);
        chk("mis_noerr", frag_err, 1'b0);
        send(2'd2, 2'd1, 3'd2, pay(4, 2));
        chk("mis_drop_pulse", frag_drop, 1'b0);
        send(2'd2, 2'd1, 3'd3, pay(4, 3));
        send(2'd2, 2'd1, 3'd4, pay(4, 4));
        chk("mis_valid", pkt_valid, 1'b1);
        chk_pkt("mis", 4, 2'd2);
        step();

        // Non-zero fragment in IDLE is dropped
        send(2'd2, 2'd1, 3'd2, pay(5, 2));
        chk("idle_drop", frag_drop, 1'b1);
        chk("idle_noerr", frag_err, 1'b0);

        // Sequence error 0,1,3 -> abort to IDLE
        send(2'd2, 2'd1, 3'd0, pay(5, 0));
        send(2'd2, 2'd1, 3'd1, pay(5, 1));
        send(2'd2, 2'd1, 3'd3, pay(5, 3));
        chk("seq_err", frag_err, 1'b1);
        chk("seq_nodrop", frag_drop, 1'b0);
        send(2'd2, 2'd1, 3'd1, pay(5, 1));
        chk("seq_idle_drop", frag_drop, 1'b1);
        chk("seq_err_pulse", frag_err, 1'b0);

        // Restart on fragment 0: 0,1,0,1,2,3,4
        send(2'd2, 2'd1, 3'd0, pay(6, 0));
        send(2'd2, 2'd1, 3'd1, pay(6, 1));
        send(2'd2, 2'd1, 3'd0, pay(7, 0));
        chk("rst0_err", frag_err, 1'b1);
        for (int i = 1; i < 5; i++) send(2'd2, 2'd1, 3'(i), pay(7, i));
        chk("rst0_valid", pkt_valid, 1'b1);
        chk("rst0_noerr", frag_err, 1'b0);
        chk_pkt("rst0", 7, 2'd2);
        step();

        // Source mismatch on fragment 2
        send(2'd2, 2'd1, 3'd0, pay(8, 0));
        send(2'd2, 2'd1, 3'd1, pay(8, 1));
        send(2'd3, 2'd1, 3'd2, pay(8, 2));
        chk("srcm_err", frag_err, 1'b1);
        step();
        step();
        chk("srcm_novalid", pkt_valid, 1'b0);
        send(2'd2, 2'd1, 3'd3, pay(8, 3));
        chk("srcm_idle_drop", frag_drop, 1'b1);

        // frag_num 5 after 3 counts as out-of-sequence
        for (int i = 0; i < 4; i++) send(2'd2, 2'd1, 3'(i), pay(9, i));
        send(2'd2, 2'd1, 3'd5, pay(9, 5));
        chk("fn5_err", frag_err, 1'b1);
        chk("fn5_novalid", pkt_valid, 1'b0);

        // Reset mid-packet, then a fresh packet from a different source
        for (int i = 0; i < 3; i++) send(2'd2, 2'd1, 3'(i), pay(10, i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", pkt_valid, 1'b0);
        chk("mrst_err", frag_err, 1'b0);
        chk("mrst_ready", frag_ready, 1'b1);
        for (int i = 0; i < 5; i++) send(2'd1, 2'd1, 3'(i), pay(11, i));
        chk("mrst_pkt_valid", pkt_valid, 1'b1);
        chk_pkt("mrst", 11, 2'd1);
        step();

`ifdef REASM_TIMEOUT_EN
        // 64 idle cycles after fragment 1 abort the packet
        send(2'd2, 2'd1, 3'd0, pay(12, 0));
        send(2'd2, 2'd1, 3'd1, pay(12, 1));
        any_err = 1'b0;
        for (int k = 0; k < 63; k++) begin
            step();
            any_err = any_err | frag_err;
        end
        chk("tmo_early", any_err, 1'b0);
        step();
        chk("tmo_err", frag_err, 1'b1);
        send(2'd2, 2'd1, 3'd2, pay(12, 2));
        chk("tmo_idle_drop", frag_drop, 1'b1);
`else
        any_err = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reassemble_pkt.md
Name: reassemble_pkt

Overview:
Receive-side counterpart of the transmit fragmenter. Takes 256-bit Aurora fragments from the receive FIFO and checks their headers. Rebuilds the 1041-bit encapsulated packet from fragments 0..4 and presents it to the decapsulation stage with a valid/ready handshake. Sits between the Aurora RX FIFO and the receive controller of each router lane.

Parameters:
PKT_WIDTH, 1041, reassembled packet width (1034 data+addr, 1 ack, 2 seq, 4 dfx)
AURORA_WIDTH, 256, fragment width
ROUTER_WIDTH, 2, router ID width
FRAG_PAYLOAD_WIDTH, 247, payload bits per fragment (AURORA_WIDTH-9)
LAST_FRAG, 4, frag_num of final fragment
TIMEOUT_CYCLES, 64, max idle cycles between fragments of one packet (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
local_router  in  2  this router's ID
frag_recv  in  256  fragment: [1:0] src, [3:2] dst, [6:4] frag_num, [8:7] TTL, [255:9] payload
frag_valid  in  1  fragment present
frag_ready  out  1  fragment consumed when frag_valid&&frag_ready
pkt_data  out  1041  reassembled packet
pkt_src_router  out  2  source router of pkt_data
pkt_valid  out  1  packet available, held until accepted
pkt_ready  in  1  downstream accepts packet
frag_drop  out  1  one-cycle pulse: fragment discarded
frag_err  out  1  one-cycle pulse: sequence/source error, partial packet aborted

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pkt_data=0, pkt_src_router=0, pkt_valid=0, frag_drop=0, frag_err=0, expected frag_num=0. A reset asserted mid-packet discards the partial packet; no error pulse.
- frag_ready = 1 in IDLE and COLLECT, 0 in HOLD. Combinational from state only.
- States: IDLE, COLLECT, HOLD.
- Accepted fragment with dst != local_router:
  - frag_drop pulses; the fragment is ignored.
  - State, expected count and partial data are unchanged.
- IDLE, accepted fragment with matching dst:
  - frag_num==0: store payload into pkt_data[246:0], latch src, expected=1, go to COLLECT.
  - frag_num!=0: frag_drop pulses, stay in IDLE.
- COLLECT, accepted matching fragment with frag_num==expected and src==latched src:
  - Store payload at pkt_data[frag_num*247 +: 247]; for frag_num 0..3 the slice is exactly 247 bits.
  - frag_num==LAST_FRAG: only frag_recv[61:9] is used, written to pkt_data[1040:988]. frag_recv[255:62] is ignored. Set pkt_valid=1, go to HOLD.
  - Otherwise expected++.
- COLLECT, out-of-sequence or src mismatch:
  - frag_err pulses; the partial packet is aborted.
  - If the offending fragment has frag_num==0, restart with it: behave as IDLE acceptance, stay in COLLECT.
  - Else go to IDLE.
- HOLD: pkt_data and pkt_src_router are stable. When pkt_valid&&pkt_ready, clear pkt_valid next edge and go to IDLE. No fragment can be accepted in the handshake cycle.
- Latency: last fragment accepted at edge N, pkt_valid high after edge N. Minimum 5 cycles per packet plus 1 handshake cycle.
- TTL is not checked. frag_num values 5..7 count as out-of-sequence.
- pkt_data bits are overwritten slice by slice per packet. Stale upper bits are never visible because pkt_valid asserts only after all 5 slices are written.
- frag_drop and frag_err never assert in the same cycle.

Optional Feature:
Macro REASM_TIMEOUT_EN.
- Defined: a counter clears on each accepted fragment and increments each cycle in COLLECT. At TIMEOUT_CYCLES it pulses frag_err, aborts the partial packet and returns to IDLE.
- Undefined: no counter; COLLECT waits indefinitely.

Decomposition:
- Shared package router_pkt_pkg holds:
  - PKT_WIDTH, AURORA_WIDTH, ROUTER_WIDTH, FRAG_PAYLOAD_WIDTH, LAST_FRAG, TAIL_WIDTH=53
  - header field offsets (SRC_LSB=0, DST_LSB=2, FNUM_LSB=4, TTL_LSB=7, PAYLOAD_LSB=9)
  - state encoding.
- The package is shared with the fragmenter.
- One natural sub-module: frag_hdr_decode, a combinational field split plus dst-match/sequence-match flags. The FSM and datapath stay in reassemble_pkt.

Test Plan:
- In-order: local=2'b01; 5 fragments src=2, dst=1, nums 0..4, payloads 247'hA..E, tail 53'h1F; pkt_ready=1 -> pkt_valid one cycle after frag 4, pkt_data={53'h1F,E,D,C,B,A}, pkt_src_router=2.
- Backpressure: pkt_ready=0 for 10 cycles after completion, frag_valid held high with next packet's frag 0 -> frag_ready=0 throughout; pkt_data stable; frag 0 accepted the cycle after the handshake.
- Misrouted: dst=3 fragment inserted between nums 1 and 2 -> frag_drop pulse; packet still completes correctly.
- Sequence error: nums 0,1,3 -> frag_err on the num-3 cycle, state IDLE. Nums 0,1,0,1,2,3,4 -> frag_err on the second 0, then the packet completes from the restarted sequence.
- Source mismatch: frag 2 carries src=3 instead of 2 -> frag_err, no pkt_valid.
- Reset: rst asserted after frag 2 -> next cycle pkt_valid=0, state IDLE; a fresh 0..4 sequence completes normally. With REASM_TIMEOUT_EN, a 64-cycle gap after frag 1 -> frag_err, return to IDLE.
